dyn_brnch_pred_nb_tbl: RTL and testbench
========================================

# dyn_brnch_pred_nb_tbl

Parametrised dynamic branch predictor for the 5-stage MIPS core: a PC-indexed table of N-bit saturating counters, looked up combinationally in IF and trained when the branch leaves ID. It carries each IF prediction and table index through an internal IF/ID register so it can flag mispredictions and keep statistics. It replaces the single-state 1-bit predictor with per-branch history.

## Interface
- PC_W, 32: PC width.
- IDX_W, 6: table index width; table has 2**IDX_W entries.
- CNT_W, 2: saturating counter width (1..4).
- CNT_INIT, 1: counter reset value (weakly not-taken for CNT_W=2).
- STAT_W, 32: statistics counter width.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- if_pc  in  PC_W  PC of instruction in IF.
- brch_instr_detectd_IF  in  1  IF instruction is a conditional branch.
- brch_instr_detectd_ID  in  1  ID instruction is a conditional branch, resolved this cycle.
- actual_brch_result  in  1  resolved direction (1 = taken), valid with brch_instr_detectd_ID.
- pipe_adv  in  1  IF/ID register loads this cycle (no stall).
- flush  in  1  kill instruction entering ID.
- predict_br_taken  out  1  prediction for IF branch.
- mispredict  out  1  ID branch resolved opposite to its prediction.
- stat_br_cnt  out  STAT_W  resolved branches.
- stat_mispred_cnt  out  STAT_W  mispredictions.

## Operation
- Index: idx_if = if_pc[IDX_W+1:2] (word-aligned PC).
- predict_br_taken = table[idx_if][CNT_W-1] & brch_instr_detectd_IF (combinational).
- IF/ID register {id_vld, id_idx, id_pred}: flush=1 -> id_vld<=0 (priority); else pipe_adv=1 -> id_vld<=brch_instr_detectd_IF, id_idx<=idx_if, id_pred<=predict_br_taken; else hold.
- Update event upd = id_vld & brch_instr_detectd_ID & pipe_adv (fires once, as branch leaves ID; stall repeats nothing).
- On upd: taken -> table[id_idx] +1 saturating at 2**CNT_W-1; not-taken -> -1 saturating at 0.
- mispredict = id_vld & brch_instr_detectd_ID & (id_pred != actual_brch_result); combinational, shown every cycle of a stall.
- On upd: stat_br_cnt +1; if mispredict, stat_mispred_cnt +1; both saturate at all-ones.
- brch_instr_detectd_ID with id_vld=0 (flushed slot): no update, no count, mispredict=0.

## Timing
- Reset: all table entries = CNT_INIT, id_vld=0, id_idx=0, id_pred=0, stats=0, GHR=0; predict_br_taken = CNT_INIT[CNT_W-1] & brch_instr_detectd_IF; mispredict=0.
- Lookup latency 0; training visible to lookups from the cycle after upd.
- Same-cycle lookup and update to same index: lookup returns pre-update value (no bypass).
- flush and pipe_adv together: flush wins; the ID-leaving branch still updates if upd is true.
- Reset asserted mid-operation: all state reinitialised that edge; pending ID branch discarded.

## Configuration
- DYN_BRNCH_PRED_GSHARE_EN defined: IDX_W-bit global history register; idx_if = if_pc[IDX_W+1:2] ^ GHR; on upd GHR <= {GHR[IDX_W-2:0], actual_brch_result}; id_idx carries the XORed index so training hits the looked-up entry.
- Undefined: no GHR, pure PC indexing as above.

## Structure
- Package br_pred_pkg: cnt_t sat_inc/sat_dec functions, CNT_W-parametrised counter typedef, IF/ID predictor record typedef (vld, idx, pred).
- One sub-module: br_sat_stat_cnt (STAT_W saturating event counter), instantiated twice.

## Test plan
- Reset, CNT_W=2: branch at if_pc=0x40 -> predict_br_taken=0; brch_instr_detectd_IF=0 -> 0.
- Branch at 0x40 resolved taken twice (pipe_adv=1) -> entry 16 goes 1->2->3; next lookup at 0x40 predicts 1; 0x44 still predicts 0.
- Entry at 3, taken again -> stays 3; entry at 0, not-taken -> stays 0.
- Predicted 0, resolved taken -> mispredict=1, stat_mispred_cnt=1, stat_br_cnt=1; held 3 cycles with pipe_adv=0 -> counts still 1, counter moves once.
- flush=1 as branch enters ID, brch_instr_detectd_ID=1 next cycle -> no table change, mispredict=0, stats unchanged.
- GSHARE_EN, IDX_W=6: after taken,taken history GHR=0x03; lookup at 0x40 reads entry 16^3=19; that entry is trained.

Source files
------------

// File: rtl/br_pred_pkg.sv
// Shared types and saturating-counter helpers for the dynamic branch predictor.
package br_pred_pkg;

  localparam int CNT_W_MAX = 4;
  localparam int IDX_W_MAX = 16;

  // Wide enough for any legal CNT_W; unused upper bits stay zero.
  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef struct packed {
    logic                 vld;
    logic [IDX_W_MAX-1:0] idx;
    logic                 pred;
  } ifid_t;

  function automatic cnt_t sat_inc(cnt_t c, cnt_t max);
    return (c >= max) ? max : c + cnt_t'(1);
  endfunction

  function automatic cnt_t sat_dec(cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/br_sat_stat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module br_sat_stat_cnt #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  output logic [STAT_W-1:0] cnt_o
);

  logic [STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dyn_brnch_pred_nb_tbl.sv
// Table of saturating counters looked up in IF, trained as the branch leaves ID.
// Define DYN_BRNCH_PRED_GSHARE_EN to XOR a global history register into the index.
module dyn_brnch_pred_nb_tbl
  import br_pred_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              brch_instr_detectd_IF,
  input  logic              brch_instr_detectd_ID,
  input  logic              actual_brch_result,
  input  logic              pipe_adv,
  input  logic              flush,
  output logic              predict_br_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_br_cnt,
  output logic [STAT_W-1:0] stat_mispred_cnt
);

  localparam int   ENTRIES = 1 << IDX_W;
  localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_W) - 1);
  localparam cnt_t CNT_RST = cnt_t'(CNT_INIT);

  cnt_t             tbl_q [ENTRIES];
  cnt_t             tbl_d [ENTRIES];
  ifid_t            id_q, id_d;
  logic [IDX_W-1:0] idx_if;
  logic             upd;
  logic             unused_pc;

  assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

`ifdef DYN_BRNCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign idx_if = if_pc[IDX_W+1:2] ^ ghr_q;
  assign ghr_d  = upd ? {ghr_q[IDX_W-2:0], actual_brch_result} : ghr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign idx_if = if_pc[IDX_W+1:2];
`endif

  assign predict_br_taken = tbl_q[idx_if][CNT_W-1] & brch_instr_detectd_IF;
  assign mispredict = id_q.vld & brch_instr_detectd_ID & (id_q.pred != actual_brch_result);
  // Gated by pipe_adv so a stalled branch trains and counts exactly once.
  assign upd = id_q.vld & brch_instr_detectd_ID & pipe_adv;

  always_comb begin
    id_d = id_q;
    if (flush) begin
      id_d.vld = 1'b0;
    end else if (pipe_adv) begin
      id_d.vld  = brch_instr_detectd_IF;
      id_d.idx  = IDX_W_MAX'(idx_if);
      id_d.pred = predict_br_taken;
    end
  end

  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      tbl_d[e] = tbl_q[e];
      if (upd && (id_q.idx == IDX_W_MAX'(e)))
        tbl_d[e] = actual_brch_result ? sat_inc(tbl_q[e], CNT_MAX) : sat_dec(tbl_q[e]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q <= '0;
      for (int e = 0; e < ENTRIES; e++) tbl_q[e] <= CNT_RST;
    end else begin
      id_q <= id_d;
      for (int e = 0; e < ENTRIES; e++) tbl_q[e] <= tbl_d[e];
    end
  end

  br_sat_stat_cnt #(.STAT_W(STAT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (upd),
    .cnt_o (stat_br_cnt)
  );

  br_sat_stat_cnt #(.STAT_W(STAT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (upd & mispredict),
    .cnt_o (stat_mispred_cnt)
  );

endmodule

// File: tb/tb_dyn_brnch_pred_nb_tbl.sv
// Bench for dyn_brnch_pred_nb_tbl: directed vector table, gshare corner, random vs model.
module tb_dyn_brnch_pred_nb_tbl;

  logic        clk, rst_n;
  logic [31:0] if_pc;
  logic        brch_instr_detectd_IF, brch_instr_detectd_ID, actual_brch_result;
  logic        pipe_adv, flush;
  logic        predict_br_taken, mispredict;
  logic [31:0] stat_br_cnt, stat_mispred_cnt;

  dyn_brnch_pred_nb_tbl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .if_pc                 (if_pc),
    .brch_instr_detectd_IF (brch_instr_detectd_IF),
    .brch_instr_detectd_ID (brch_instr_detectd_ID),
    .actual_brch_result    (actual_brch_result),
    .pipe_adv              (pipe_adv),
    .flush                 (flush),
    .predict_br_taken      (predict_br_taken),
    .mispredict            (mispredict),
    .stat_br_cnt           (stat_br_cnt),
    .stat_mispred_cnt      (stat_mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: one integer counter per entry, in-flight branch as plain fields.
  int     m_tbl [64];
  bit     m_vld;
  int     m_idx;
  bit     m_pred;
  int     m_ghr;
  longint m_br, m_mc;

  logic        s_pred, s_mis;
  logic [31:0] s_br, s_mc;

  typedef struct {
    bit          r;
    logic [31:0] pc;
    bit          bif, bid, act, adv, fl;
    bit          ep, em;
    int          eb, emc;
  } vec_t;

  vec_t dv [22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'h3f);
`ifdef DYN_BRNCH_PRED_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  task automatic m_clock(input bit r, input logic [31:0] pc,
                         input bit bif, input bit bid, input bit act, input bit adv, input bit fl);
    int i;
    bit p, u;
    if (!r) begin
      foreach (m_tbl[k]) m_tbl[k] = 1;
      m_vld = 0; m_idx = 0; m_pred = 0; m_ghr = 0; m_br = 0; m_mc = 0;
    end else begin
      i = lidx(pc);
      p = bif && (m_tbl[i] >= 2);
      u = m_vld && bid && adv;
      if (u) begin
        m_br++;
        if (m_pred != act) m_mc++;
        if (act) m_tbl[m_idx] = (m_tbl[m_idx] == 3) ? 3 : m_tbl[m_idx] + 1;
        else     m_tbl[m_idx] = (m_tbl[m_idx] == 0) ? 0 : m_tbl[m_idx] - 1;
        m_ghr = ((m_ghr << 1) | int'(act)) % 64;
      end
      if (fl) m_vld = 0;
      else if (adv) begin
        m_vld = bif; m_idx = i; m_pred = p;
      end
    end
  endtask

  // One cycle: drive, sample and check at negedge, advance model at posedge.
  task automatic step(input bit r, input logic [31:0] pc,
                      input bit bif, input bit bid, input bit act, input bit adv, input bit fl);
    bit ep, em;
    rst_n = r; if_pc = pc;
    brch_instr_detectd_IF = bif; brch_instr_detectd_ID = bid;
    actual_brch_result = act; pipe_adv = adv; flush = fl;
    @(negedge clk);
    ep = bif && (m_tbl[lidx(pc)] >= 2);
    em = m_vld && bid && (m_pred != act);
    s_pred = predict_br_taken; s_mis = mispredict;
    s_br = stat_br_cnt; s_mc = stat_mispred_cnt;
    chk("model_pred", 64'(s_pred), 64'(ep));
    chk("model_mis", 64'(s_mis), 64'(em));
    chk("model_brcnt", 64'(s_br), 64'(m_br));
    chk("model_miscnt", 64'(s_mc), 64'(m_mc));
    @(posedge clk);
    m_clock(r, pc, bif, bid, act, adv, fl);
    #1;
  endtask

  initial begin
    logic [31:0] rv;
    logic [2:0]  k;
    dv[0]  = '{0, 32'h40, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    dv[1]  = '{1, 32'h40, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    dv[2]  = '{1, 32'h44, 0, 1, 1, 1, 0, 0, 1, 0, 0};
    dv[3]  = '{1, 32'h40, 1, 0, 0, 1, 0, 1, 0, 1, 1};
    dv[4]  = '{1, 32'h44, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    dv[5]  = '{1, 32'h40, 1, 1, 0, 1, 0, 1, 0, 2, 1};
    dv[6]  = '{1, 32'h44, 1, 1, 1, 1, 0, 0, 0, 3, 1};
    dv[7]  = '{1, 32'h40, 1, 1, 0, 1, 0, 1, 0, 4, 1};
    dv[8]  = '{1, 32'h44, 1, 1, 0, 1, 0, 0, 1, 5, 1};
    dv[9]  = '{1, 32'h40, 1, 1, 1, 0, 0, 1, 1, 6, 2};
    dv[10] = '{1, 32'h40, 1, 1, 1, 0, 0, 1, 1, 6, 2};
    dv[11] = '{1, 32'h40, 1, 1, 1, 0, 0, 1, 1, 6, 2};
    dv[12] = '{1, 32'h40, 1, 1, 1, 1, 0, 1, 1, 6, 2};
    dv[13] = '{1, 32'h44, 1, 0, 0, 1, 0, 0, 0, 7, 3};
    dv[14] = '{1, 32'h40, 1, 0, 0, 1, 1, 1, 0, 7, 3};
    dv[15] = '{1, 32'h44, 0, 1, 1, 1, 0, 0, 0, 7, 3};
    dv[16] = '{1, 32'h44, 1, 0, 0, 1, 0, 0, 0, 7, 3};
    dv[17] = '{1, 32'h40, 1, 1, 1, 1, 1, 1, 1, 7, 3};
    dv[18] = '{1, 32'h44, 1, 1, 0, 1, 0, 1, 0, 8, 4};
    dv[19] = '{0, 32'h44, 1, 1, 0, 1, 0, 1, 1, 8, 4};
    dv[20] = '{1, 32'h44, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    dv[21] = '{1, 32'h40, 1, 0, 0, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0; if_pc = '0;
    brch_instr_detectd_IF = 0; brch_instr_detectd_ID = 0;
    actual_brch_result = 0; pipe_adv = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    m_clock(0, '0, 0, 0, 0, 0, 0);

`ifndef DYN_BRNCH_PRED_GSHARE_EN
    for (int i = 0; i < 22; i++) begin
      step(dv[i].r, dv[i].pc, dv[i].bif, dv[i].bid, dv[i].act, dv[i].adv, dv[i].fl);
      chk($sformatf("vec%0d_pred", i), 64'(s_pred), 64'(dv[i].ep));
      chk($sformatf("vec%0d_mis", i), 64'(s_mis), 64'(dv[i].em));
      chk($sformatf("vec%0d_brcnt", i), 64'(s_br), 64'(dv[i].eb));
      chk($sformatf("vec%0d_miscnt", i), 64'(s_mc), 64'(dv[i].emc));
    end
`else
    // Two taken resolutions give history 0x03; 0x40 then reads entry 19 (still 1), not 16 (3).
    step(0, 32'h40, 1, 0, 0, 1, 0);
    step(1, 32'h40, 1, 0, 0, 1, 0);
    step(1, 32'h40, 1, 1, 1, 1, 0);
    step(1, 32'h40, 1, 1, 1, 1, 0);
    step(1, 32'h40, 1, 0, 0, 1, 0);
    chk("gshare_idx19_pred", 64'(s_pred), 64'(0));
    chk("gshare_brcnt", 64'(s_br), 64'(2));
    step(1, 32'h40, 1, 1, 1, 1, 0);
    step(1, 32'h40, 1, 1, 1, 1, 0);
    step(1, 32'h40, 1, 0, 0, 1, 0);
`endif

    step(0, 32'h0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      rv = $urandom();
      k  = 3'($urandom_range(0, 7));
      step($urandom_range(0, 199) != 0, {rv[31:5], k, 2'b00},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
